rx_control_unit: RTL and testbench

- Receive control FSM for the flexible-rate serial receiver.
- Sequences the bit timer (bit-period strobe counter plus bit counter) and the data buffer.
- Flow: detects a start edge, re-checks the line at the start-bit centre, runs the timer for data_size data bits plus one stop bit, validates the stop bit, then loads the RX buffer.
- Owns the data_ready/data_read handshake to the host side and reports framing and overrun errors.

---
 rtl/rx_control_unit.sv | 127 ++++++++++++
 tb/tb_rx_control_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_control_unit.sv
// Receive control FSM: start-bit qualification, bit-timer enable, stop-bit check and
// RX buffer load, plus the data_ready/data_read handshake and framing/overrun flags.
module rx_control_unit #(
    parameter int BP_BITS = 14
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start_bit_detected,
    input  logic               serial_in,
    input  logic [BP_BITS-1:0] bit_period,
    input  logic               packet_done,
    input  logic               stop_bit,
    input  logic               data_read,
    output logic               enable_timer,
    output logic               load_buffer,
    output logic               data_ready,
    output logic               framing_error,
    output logic               overrun_error,
    output logic               false_start
);

    // state      | meaning
    // IDLE       | waiting for a start edge
    // START_WAIT | counting to the start-bit centre, then re-checking the line
    // RECEIVE    | bit timer running over data bits and stop bit
    // STOP_CHK   | one cycle: validate stop bit
    // LOAD       | one cycle: copy shift register into RX buffer
    typedef enum logic [2:0] {
        IDLE,
        START_WAIT,
        RECEIVE,
        STOP_CHK,
        LOAD
    } state_t;

    localparam logic [BP_BITS-1:0] ONE = {{(BP_BITS-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [BP_BITS-1:0] half_cnt_q, half_cnt_d;
    logic               data_ready_q, data_ready_d;
    logic               framing_error_q, framing_error_d;
    logic               overrun_error_q, overrun_error_d;
    logic [BP_BITS-1:0] half_raw;
    logic [BP_BITS-1:0] half;

    // A bit period of 0 or 1 would give a zero half-period; clamp so the centre check still happens.
    assign half_raw = bit_period >> 1;
    assign half     = (half_raw == '0) ? ONE : half_raw;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            half_cnt_q      <= '0;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            half_cnt_q      <= half_cnt_d;
            data_ready_q    <= data_ready_d;
            framing_error_q <= framing_error_d;
            overrun_error_q <= overrun_error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        half_cnt_d      = half_cnt_q;
        data_ready_d    = data_ready_q;
        framing_error_d = framing_error_q;
        overrun_error_d = overrun_error_q;
        enable_timer    = 1'b0;
        load_buffer     = 1'b0;
        false_start     = 1'b0;

        // A host read clears the flags, except in LOAD where the new byte takes priority.
        if (data_read && (state_q != LOAD)) begin
            data_ready_d    = 1'b0;
            overrun_error_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_bit_detected) begin
                    state_d    = START_WAIT;
                    half_cnt_d = ONE;
                end
            end
            START_WAIT: begin
                half_cnt_d = half_cnt_q + ONE;
                if (half_cnt_q == half) begin
                    if (!serial_in) begin
                        state_d         = RECEIVE;
                        framing_error_d = 1'b0;
                    end else begin
                        state_d     = IDLE;
                        false_start = 1'b1;
                    end
                end
            end
            RECEIVE: begin
                enable_timer = 1'b1;
                if (packet_done) state_d = STOP_CHK;
            end
            STOP_CHK: begin
                if (stop_bit) begin
                    state_d = LOAD;
                end else begin
                    framing_error_d = 1'b1;
                    state_d         = IDLE;
                end
            end
            LOAD: begin
                load_buffer  = 1'b1;
                data_ready_d = 1'b1;
                if (data_ready_q && !data_read) overrun_error_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_ready    = data_ready_q;
    assign framing_error = framing_error_q;
    assign overrun_error = overrun_error_q;

endmodule

// File: tb/tb_rx_control_unit.sv
// Self-checking bench for rx_control_unit: per-frame outcomes go through a scoreboard queue,
// flag values are compared against a small reference model kept by the stimulus tasks.
module tb_rx_control_unit;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start_bit_detected;
    logic        serial_in;
    logic [13:0] bit_period;
    logic        packet_done;
    logic        stop_bit;
    logic        data_read;
    logic        enable_timer;
    logic        load_buffer;
    logic        data_ready;
    logic        framing_error;
    logic        overrun_error;
    logic        false_start;

    int n_checks = 0;
    int n_fails  = 0;

    // Outcome codes: 1 = false start, 2 = buffer load, 3 = framing error
    int sb_q[$];

    bit m_dr, m_fe, m_ov;

    rx_control_unit #(.BP_BITS(14)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_bit_detected (start_bit_detected),
        .serial_in          (serial_in),
        .bit_period         (bit_period),
        .packet_done        (packet_done),
        .stop_bit           (stop_bit),
        .data_read          (data_read),
        .enable_timer       (enable_timer),
        .load_buffer        (load_buffer),
        .data_ready         (data_ready),
        .framing_error      (framing_error),
        .overrun_error      (overrun_error),
        .false_start        (false_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every outcome the DUT produces must match the next queued expectation.
    bit fe_prev = 1'b0;
    always @(negedge clk) begin
        int kind;
        kind = 0;
        if (false_start) kind = 1;
        else if (load_buffer) kind = 2;
        else if (framing_error && !fe_prev) kind = 3;
        fe_prev = framing_error;
        if (kind != 0) begin
            if (sb_q.size() == 0) chk("sb_unexpected", kind, 0);
            else chk("sb_outcome", kind, sb_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_dr"}, data_ready, m_dr);
        chk({tag, "_fe"}, framing_error, m_fe);
        chk({tag, "_ov"}, overrun_error, m_ov);
    endtask

    // Drives one frame starting in IDLE; caller is at #1 after a posedge (cycle 0).
    task automatic send_frame(input int bp, input bit glitch, input bit stop, input bit rd_at_load);
        int h;
        h = bp >> 1;
        if (h == 0) h = 1;
        bit_period = bp[13:0];
        if (glitch) sb_q.push_back(1);
        else if (stop) sb_q.push_back(2);
        else sb_q.push_back(3);

        start_bit_detected = 1'b1;
        serial_in          = 1'b0;
        #1;
        chk("c0_en", enable_timer, 0);
        for (int c = 1; c <= h; c++) begin
            tick();
            start_bit_detected = 1'b1;
            if (c == h && glitch) serial_in = 1'b1;
            #1;
            chk("sw_en", enable_timer, 0);
            chk("sw_fs", false_start, (c == h && glitch) ? 1 : 0);
            if (c == h) chk("sw_fe_hold", framing_error, m_fe);
        end
        tick();
        start_bit_detected = 1'b0;
        serial_in          = 1'b1;
        #1;
        if (glitch) begin
            chk("gl_en", enable_timer, 0);
            chk("gl_fs", false_start, 0);
            chk("gl_lb", load_buffer, 0);
            return;
        end
        m_fe = 1'b0;
        chk("rx_en_rise", enable_timer, 1);
        chk_flags("rx");
        for (int r = 1; r <= 3; r++) begin
            tick();
            start_bit_detected = (r == 2);
            #1;
            chk("rx_en", enable_timer, 1);
        end
        packet_done = 1'b1;
        tick();
        packet_done        = 1'b0;
        start_bit_detected = 1'b0;
        stop_bit           = stop;
        #1;
        chk("sc_en", enable_timer, 0);
        chk("sc_lb", load_buffer, 0);
        tick();
        stop_bit  = 1'b1;
        data_read = rd_at_load;
        #1;
        if (stop) begin
            chk("ld_lb", load_buffer, 1);
            if (m_dr && !rd_at_load) m_ov = 1'b1;
            m_dr = 1'b1;
        end else begin
            chk("fe_lb", load_buffer, 0);
            m_fe = 1'b1;
        end
        tick();
        data_read = 1'b0;
        #1;
        chk("post_en", enable_timer, 0);
        chk_flags("post");
    endtask

    task automatic host_read();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        m_dr = 1'b0;
        m_ov = 1'b0;
        #1;
        chk_flags("read");
    endtask

    initial begin
        n_rst = 1'b0;
        start_bit_detected = 1'b0;
        serial_in = 1'b1;
        bit_period = 14'd10;
        packet_done = 1'b0;
        stop_bit = 1'b1;
        data_read = 1'b0;
        m_dr = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        #12;
        chk("rst_en", enable_timer, 0);
        chk("rst_lb", load_buffer, 0);
        chk("rst_fs", false_start, 0);
        chk_flags("rst");
        n_rst = 1'b1;
        tick(); tick();

        send_frame(10, 1'b0, 1'b1, 1'b0);      // clean frame
        tick();
        send_frame(10, 1'b1, 1'b1, 1'b0);      // glitch rejected at centre
        tick();
        send_frame(10, 1'b0, 1'b1, 1'b0);      // second load without read: overrun
        tick();
        host_read();
        send_frame(10, 1'b0, 1'b0, 1'b0);      // bad stop bit
        tick();
        send_frame(7, 1'b0, 1'b1, 1'b0);       // clears framing error, loads
        tick();
        send_frame(10, 1'b0, 1'b1, 1'b1);      // read coincides with load
        tick();
        send_frame(1, 1'b0, 1'b1, 1'b0);       // HALF clamps to 1: overrun again
        tick();
        host_read();
        send_frame(0, 1'b1, 1'b1, 1'b0);
        tick();

        // Reset in the middle of RECEIVE
        bit_period = 14'd4;
        start_bit_detected = 1'b1;
        serial_in = 1'b0;
        tick();
        start_bit_detected = 1'b0;
        tick();
        tick();
        #1;
        chk("mr_en", enable_timer, 1);
        n_rst = 1'b0;
        #1;
        m_dr = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        chk("mr_en_drop", enable_timer, 0);
        chk("mr_lb", load_buffer, 0);
        chk("mr_fs", false_start, 0);
        chk_flags("mr");
        tick();
        n_rst = 1'b1;
        serial_in = 1'b1;
        tick();
        send_frame(10, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        chk("sb_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
